// File: rtl/spad_frame_packer.sv
// -----------------------------------------------------------------------------
// spad_frame_packer
//
// Packs the serial SPAD pixel stream (one pixel per ReadEnable cycle, in
// raster order) into 33-word frames on an AXI4-Stream master:
//   word 0      : FrameId captured at frame start (tuser=0, tlast=0)
//   words 1..32 : 32 data words of 32 pixels each, tlast on the last one
// A frame is only started when the output FIFO has room for all 33 words, so
// the FIFO can never overflow. Frames that cannot be started, or that collide
// with a frame already in progress, are dropped and counted. A pixel arriving
// out of order aborts the frame: the remaining words are padded with zeros
// and flagged with tuser=1 so the stream framing is preserved.
//
// Ports
//   clk             sole clock, rising edge
//   reset           synchronous, active low
//   LatchSpad       latch strobe, rising edge = frame start
//   ReadEnable      SpadPixel valid this cycle
//   RowSelect[2:0]  pixel row address
//   ColSelect[5:0]  pixel column address
//   HighLowRows     half-array select
//   SpadPixel       pixel hit bit
//   FrameId[31:0]   frame number, captured at frame start
//   m_axis_*        stream output (tuser = frame-error flag)
//   DroppedFrames   saturating count of frames not emitted
//   SeqError        sticky pixel-order violation flag
//   FifoLevel       current output FIFO occupancy in words
// -----------------------------------------------------------------------------
module spad_frame_packer #(
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          LatchSpad,
    input  logic                          ReadEnable,
    input  logic [2:0]                    RowSelect,
    input  logic [5:0]                    ColSelect,
    input  logic                          HighLowRows,
    input  logic                          SpadPixel,
    input  logic [31:0]                   FrameId,
    output logic [31:0]                   m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tuser,
    output logic [15:0]                   DroppedFrames,
    output logic                          SeqError,
    output logic [$clog2(FIFO_DEPTH):0]   FifoLevel
);

    localparam int AW          = $clog2(FIFO_DEPTH);
    localparam int LW          = AW + 1;
    localparam int FRAME_WORDS = 33;
    // A new frame may start only if the whole frame still fits.
    localparam logic [LW-1:0] ROOM_LIMIT = LW'(FIFO_DEPTH - FRAME_WORDS);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        FILL    = 2'd2,
        SKIP    = 2'd3
    } state_t;

    // FIFO entry layout: {tuser, tlast, tdata}
    typedef logic [33:0] entry_t;

    // ---------------------------------------------------------------- state
    state_t         state_reg;
    logic           latch_prev_reg;
    logic [9:0]     expected_reg;       // next pixel index expected in order
    logic [31:0]    word_reg;           // data word under assembly
    logic [4:0]     fill_word_reg;      // data word index being padded
    logic [15:0]    dropped_reg;
    logic [15:0]    dropped_next;
    logic           seq_error_reg;

    // ---------------------------------------------------------------- FIFO
    entry_t         mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [LW-1:0]  mem_count_reg;      // words in RAM, excluding output reg
    entry_t         out_entry_reg;
    logic           out_valid_reg;
    logic [LW-1:0]  fifo_level;
    logic           fifo_pop;
    logic           fifo_load;

    // ---------------------------------------------------------------- decode
    logic [9:0]     pixel_index;
    logic           frame_start;
    logic           has_room;
    logic           can_restart;
    logic           start_ok;
    logic           start_drop;
    logic           collect_active;
    logic           pixel_hit;
    logic           pixel_miss;
    logic           word_done;
    logic           push_en;
    entry_t         push_entry;
    logic [31:0]    word_with_pixel;

    assign pixel_index = {HighLowRows, RowSelect, ColSelect};
    assign frame_start = LatchSpad & ~latch_prev_reg;
    assign fifo_level  = mem_count_reg + LW'(out_valid_reg);
    assign has_room    = (fifo_level <= ROOM_LIMIT);

    // A frame start may open a new frame from IDLE/SKIP, or from COLLECT
    // before any pixel of the current frame has been accepted.
    assign can_restart = (state_reg == IDLE) || (state_reg == SKIP) ||
                         ((state_reg == COLLECT) && (expected_reg == 10'd0));
    assign start_ok    = frame_start & can_restart & has_room;
    assign start_drop  = frame_start & ~start_ok;

    // Frame start has priority over a pixel presented in the same cycle.
    assign collect_active = (state_reg == COLLECT) & ~frame_start & ReadEnable;
    assign pixel_hit      = collect_active & (pixel_index == expected_reg);
    assign pixel_miss     = collect_active & (pixel_index != expected_reg);
    assign word_done      = pixel_hit & (expected_reg[4:0] == 5'd31);

    assign push_en = start_ok | word_done | (state_reg == FILL);

    // Current word with the incoming pixel merged at its bit position, so the
    // completed word can be pushed on the same edge its last bit arrives.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_merge
            assign word_with_pixel[gi] = (expected_reg[4:0] == 5'(gi)) ?
                                         SpadPixel : word_reg[gi];
        end
    endgenerate

    always_comb begin
        push_entry = {1'b1, (fill_word_reg == 5'd31), 32'h0};
        if (start_ok) begin
            push_entry = {2'b00, FrameId};
        end else if (word_done) begin
            push_entry = {1'b0, (expected_reg[9:5] == 5'd31), word_with_pixel};
        end
    end

    always_comb begin
        dropped_next = dropped_reg;
        if (start_drop && (dropped_reg != 16'hFFFF)) begin
            dropped_next = dropped_reg + 16'd1;
        end
    end

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            latch_prev_reg <= 1'b0;
            expected_reg   <= '0;
            word_reg       <= '0;
            fill_word_reg  <= '0;
            dropped_reg    <= '0;
            seq_error_reg  <= 1'b0;
        end else begin
            latch_prev_reg <= LatchSpad;
            dropped_reg    <= dropped_next;
            case (state_reg)
                IDLE, SKIP: begin
                    if (frame_start) begin
                        expected_reg <= '0;
                        if (start_ok) begin
                            state_reg <= COLLECT;
                        end else begin
                            state_reg <= SKIP;
                        end
                    end
                end
                COLLECT: begin
                    if (frame_start) begin
                        if (start_ok) begin
                            expected_reg <= '0;
                        end else if (expected_reg == 10'd0) begin
                            state_reg <= SKIP;
                        end else begin
                            // Pad the rest of the current frame; the
                            // partial word is discarded.
                            state_reg     <= FILL;
                            fill_word_reg <= expected_reg[9:5];
                        end
                    end else if (pixel_hit) begin
                        word_reg     <= word_with_pixel;
                        expected_reg <= expected_reg + 10'd1;
                        if (expected_reg == 10'd1023) begin
                            state_reg <= IDLE;
                        end
                    end else if (pixel_miss) begin
                        seq_error_reg <= 1'b1;
                        state_reg     <= FILL;
                        fill_word_reg <= expected_reg[9:5];
                    end
                end
                FILL: begin
                    fill_word_reg <= fill_word_reg + 5'd1;
                    if (fill_word_reg == 5'd31) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- FIFO
    // Block RAM with a registered read feeding a first-word-fall-through
    // output register. The output register is refilled whenever it is empty
    // or being popped; FifoLevel counts RAM words plus the output register.
    assign fifo_pop  = out_valid_reg & m_axis_tready;
    assign fifo_load = (mem_count_reg != '0) & (~out_valid_reg | fifo_pop);

    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            out_entry_reg <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (fifo_load) begin
                out_entry_reg <= mem[rd_ptr_reg];
                rd_ptr_reg    <= rd_ptr_reg + AW'(1);
                out_valid_reg <= 1'b1;
            end else if (fifo_pop) begin
                out_valid_reg <= 1'b0;
            end
            mem_count_reg <= mem_count_reg + LW'(push_en) - LW'(fifo_load);
        end
    end

    // Space is reserved at frame start, so a push into a full FIFO means the
    // reservation logic is broken.
    assert property (@(posedge clk) disable iff (!reset)
                     !(push_en && (fifo_level == FULL_LEVEL)));

    // ---------------------------------------------------------------- outputs
    assign m_axis_tdata  = out_entry_reg[31:0];
    assign m_axis_tlast  = out_entry_reg[32];
    assign m_axis_tuser  = out_entry_reg[33];
    assign m_axis_tvalid = out_valid_reg;
    assign DroppedFrames = dropped_reg;
    assign SeqError      = seq_error_reg;
    assign FifoLevel     = fifo_level;

endmodule
